// File: rtl/snn_layer_if.sv
// snn_layer_if: signal bundle between the layer sequencer and its datapath
// (input-unit RAM, weight ROM, shared MAC, activation LUT, output RAM).
//   start     : begin layer evaluation
//   busy/done : layer in progress / one-cycle completion pulse
//   addr_in   : input RAM read address
//   addr_w    : weight ROM read address
//   mac_clr_n : active-low synchronous MAC clear
//   mac_en    : MAC accumulate enable
//   acc       : signed 26-bit MAC accumulator
//   addr_lut  : activation LUT address
//   lut_q     : LUT data (1-cycle read latency)
//   out_we/out_addr/out_data : output RAM write port
//   max_idx/max_val : running argmax (only when SNN_ARGMAX_EN is defined)
// Modports: master = sequencer side, slave = datapath/environment side.
interface snn_layer_if #(
  parameter int IN_AW  = 10,
  parameter int W_AW   = 15,
  parameter int OUT_AW = 5
);
  logic                     start;
  logic                     busy;
  logic                     done;
  logic [IN_AW-1:0]         addr_in;
  logic [W_AW-1:0]          addr_w;
  logic                     mac_clr_n;
  logic                     mac_en;
  logic signed [25:0]       acc;
  logic [10:0]              addr_lut;
  logic [7:0]               lut_q;
  logic                     out_we;
  logic [OUT_AW-1:0]        out_addr;
  logic [7:0]               out_data;
`ifdef SNN_ARGMAX_EN
  logic [OUT_AW-1:0]        max_idx;
  logic signed [7:0]        max_val;

  modport master (
    input  start, acc, lut_q,
    output busy, done, addr_in, addr_w, mac_clr_n, mac_en, addr_lut,
           out_we, out_addr, out_data, max_idx, max_val
  );
  modport slave (
    output start, acc, lut_q,
    input  busy, done, addr_in, addr_w, mac_clr_n, mac_en, addr_lut,
           out_we, out_addr, out_data, max_idx, max_val
  );
`else
  modport master (
    input  start, acc, lut_q,
    output busy, done, addr_in, addr_w, mac_clr_n, mac_en, addr_lut,
           out_we, out_addr, out_data
  );
  modport slave (
    output start, acc, lut_q,
    input  busy, done, addr_in, addr_w, mac_clr_n, mac_en, addr_lut,
           out_we, out_addr, out_data
  );
`endif
endinterface

// File: rtl/snn_layer_seq.sv
// snn_layer_seq: sequencer for one fully-connected SNN layer.
// For each output neuron: clear the MAC, stream N_IN input/weight address
// pairs, drain, saturate the accumulator into an 11-bit LUT address, wait
// for the LUT read and write the 8-bit activation to the output RAM.
// Ports:
//   clk  : clock, all state on rising edge
//   rst  : asynchronous active-high reset (aborts to IDLE)
//   bus  : snn_layer_if.master (start/busy/done, RAM/ROM/LUT addresses,
//          MAC control, accumulator input, output RAM write port)
// Optional feature: define SNN_ARGMAX_EN to add a running argmax
// (bus.max_idx / bus.max_val) over the written activations.
module snn_layer_seq #(
  parameter int N_IN   = 784,
  parameter int N_OUT  = 32,
  parameter int IN_AW  = 10,
  parameter int W_AW   = 15,
  parameter int OUT_AW = 5
) (
  input  logic         clk,
  input  logic         rst,
  snn_layer_if.master  bus
);

  localparam logic [IN_AW-1:0]  I_LAST = IN_AW'(N_IN - 1);
  localparam logic [OUT_AW-1:0] N_LAST = OUT_AW'(N_OUT - 1);

  typedef enum logic [3:0] {
    IDLE, CLR, ISSUE, DRAIN0, DRAIN1, SAT, LUTW, WRITE, DONE
  } state_t;

  state_t             state, state_nxt;
  logic [IN_AW-1:0]   i;
  logic [OUT_AW-1:0]  n;
  logic [W_AW-1:0]    w;
  logic               mac_en_p1;
  logic [10:0]        addr_lut;
  logic               busy, done, mac_clr_n, out_we;
  logic [7:0]         out_data;

  // Clamp the accumulator into the LUT range: positive overflow -> 0x3FF,
  // negative overflow -> 0x400, otherwise the window acc[17:7].
  function automatic logic [10:0] sat_lut_addr(input logic signed [25:0] a);
    if (!a[25] && (|a[24:17]))
      return 11'h3FF;
    else if (a[25] && !(&a[24:17]))
      return 11'h400;
    else
      return a[17:7];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    mac_clr_n = 1'b1;
    out_we    = 1'b0;
    out_data  = '0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (bus.start) state_nxt = CLR;
      end
      CLR: begin
        mac_clr_n = 1'b0;
        state_nxt = ISSUE;
      end
      ISSUE:  if (i == I_LAST) state_nxt = DRAIN0;
      DRAIN0: state_nxt = DRAIN1;
      DRAIN1: state_nxt = SAT;
      SAT:    state_nxt = LUTW;
      LUTW:   state_nxt = WRITE;
      WRITE: begin
        out_we    = 1'b1;
        out_data  = bus.lut_q;
        state_nxt = (n == N_LAST) ? DONE : CLR;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Counters double as the address outputs. The weight address skips its
  // increment on the last issue of a neuron (so the output holds) and makes
  // it up in the next CLR, keeping w = n*N_IN + i without a multiplier.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i         <= '0;
      n         <= '0;
      w         <= '0;
      mac_en_p1 <= 1'b0;
      addr_lut  <= '0;
    end else begin
      // stage p1: read data returns one cycle after the issued address
      mac_en_p1 <= (state == ISSUE);
      unique case (state)
        IDLE: if (bus.start) begin
          i <= '0;
          n <= '0;
          w <= '0;
        end
        CLR: if (n != '0) w <= w + 1'b1;
        ISSUE: if (i != I_LAST) begin
          i <= i + 1'b1;
          w <= w + 1'b1;
        end
        SAT: addr_lut <= sat_lut_addr(bus.acc);
        WRITE: if (n != N_LAST) begin
          n <= n + 1'b1;
          i <= '0;
        end
        default: ;
      endcase
    end
  end

`ifdef SNN_ARGMAX_EN
  logic [OUT_AW-1:0] max_idx;
  logic signed [7:0] max_val;

  // Strict greater-than keeps the lower index on ties.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_idx <= '0;
      max_val <= '0;
    end else if (state == CLR && n == '0) begin
      max_idx <= '0;
      max_val <= '0;
    end else if (state == WRITE && (($signed(bus.lut_q) > max_val) || n == '0)) begin
      max_idx <= n;
      max_val <= $signed(bus.lut_q);
    end
  end

  assign bus.max_idx = max_idx;
  assign bus.max_val = max_val;
`endif

  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.mac_clr_n = mac_clr_n;
  assign bus.mac_en    = mac_en_p1;
  assign bus.addr_in   = i;
  assign bus.addr_w    = w;
  assign bus.addr_lut  = addr_lut;
  assign bus.out_we    = out_we;
  assign bus.out_addr  = n;
  assign bus.out_data  = out_data;

endmodule

// File: tb/tb_snn_layer_seq.sv
// Testbench for snn_layer_seq: small layer (N_IN=4, N_OUT=2, or N_OUT=4 when
// SNN_ARGMAX_EN is defined) with behavioural RAM/ROM/MAC/LUT around the DUT
// and a reference computing each neuron's activation from plain arithmetic.
module tb_snn_layer_seq;
  localparam int N_IN   = 4;
`ifdef SNN_ARGMAX_EN
  localparam int N_OUT  = 4;
`else
  localparam int N_OUT  = 2;
`endif
  localparam int IN_AW  = 3;
  localparam int W_AW   = 5;
  localparam int OUT_AW = 2;
  localparam int T_LAYER = N_OUT * (N_IN + 6) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  snn_layer_if #(.IN_AW(IN_AW), .W_AW(W_AW), .OUT_AW(OUT_AW)) bus ();

  snn_layer_seq #(
    .N_IN(N_IN), .N_OUT(N_OUT), .IN_AW(IN_AW), .W_AW(W_AW), .OUT_AW(OUT_AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- environment: memories, MAC, LUT ----------------
  bit                 x_mem   [0:(1<<IN_AW)-1];
  int                 w_mem   [0:(1<<W_AW)-1];
  logic [7:0]         lut_mem [0:2047];
  logic [7:0]         am_vals [0:3];
  int                 lut_mode = 0;
  bit                 force_en = 1'b0;
  logic signed [25:0] force_val = '0;
  bit                 x_q;
  int                 w_q;
  int                 mac_acc;
  int                 wr_cnt;

  always @(posedge clk) begin
    x_q <= x_mem[bus.addr_in];
    w_q <= w_mem[bus.addr_w];
    if (!bus.mac_clr_n)  mac_acc <= 0;
    else if (bus.mac_en) mac_acc <= mac_acc + (x_q ? w_q : 0);
  end

  always @(posedge clk) begin
    if (bus.start && !bus.busy) wr_cnt <= 0;
    else if (bus.out_we)        wr_cnt <= wr_cnt + 1;
  end

  always @(posedge clk) begin
    case (lut_mode)
      1:       bus.lut_q <= 8'h10 + 8'(wr_cnt);
      2:       bus.lut_q <= am_vals[wr_cnt % 4];
      default: bus.lut_q <= lut_mem[bus.addr_lut];
    endcase
  end

  assign bus.acc = force_en ? force_val : mac_acc[25:0];

  // ---------------- reference ----------------
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_data [0:N_OUT-1];

  function automatic logic [10:0] ref_lut_addr(input int a);
    int q;
    q = a >>> 7;
    if (q > 1023)  q = 1023;
    if (q < -1024) q = -1024;
    return q[10:0];
  endfunction

  task automatic prepare();
    for (int k = 0; k < N_OUT; k++) begin
      int s;
      s = 0;
      for (int j = 0; j < N_IN; j++)
        if (x_mem[j]) s += w_mem[k * N_IN + j];
      if (force_en) s = int'(force_val);
      case (lut_mode)
        1:       exp_data[k] = 8'h10 + 8'(k);
        2:       exp_data[k] = am_vals[k];
        default: exp_data[k] = lut_mem[ref_lut_addr(s)];
      endcase
    end
  endtask

  task automatic randomize_env();
    for (int k = 0; k < (1 << IN_AW); k++) x_mem[k] = bit'($urandom_range(1));
    for (int k = 0; k < (1 << W_AW); k++)  w_mem[k] = int'($urandom_range(131071)) - 65536;
    for (int k = 0; k < 2048; k++)         lut_mem[k] = 8'($urandom);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_busy"},      32'(bus.busy), 0);
    chk({tag, "_done"},      32'(bus.done), 0);
    chk({tag, "_mac_clr_n"}, 32'(bus.mac_clr_n), 1);
    chk({tag, "_mac_en"},    32'(bus.mac_en), 0);
    chk({tag, "_out_we"},    32'(bus.out_we), 0);
    chk({tag, "_addr_in"},   32'(bus.addr_in), 0);
    chk({tag, "_addr_w"},    32'(bus.addr_w), 0);
    chk({tag, "_addr_lut"},  32'(bus.addr_lut), 0);
    chk({tag, "_out_addr"},  32'(bus.out_addr), 0);
    chk({tag, "_out_data"},  32'(bus.out_data), 0);
  endtask

  // One full layer pass. start is held high for start_hold extra cycles
  // while busy (must be ignored). Issued addresses are checked against the
  // cycle where mac_en later goes high, which also checks the 1-cycle lag.
  task automatic run_pass(input string tag, input int start_hold);
    int cyc, done_cyc, done_cnt, en_cnt, clr_cnt, busy_bad, iss_bad, wr_n;
    bit seen_done;
    logic [IN_AW-1:0] pa_in;
    logic [W_AW-1:0]  pa_w;
    cyc = 1; done_cyc = -1; done_cnt = 0; en_cnt = 0; clr_cnt = 0;
    busy_bad = 0; iss_bad = 0; wr_n = 0; seen_done = 1'b0;
    pa_in = '0; pa_w = '0;
    prepare();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    while (cyc <= T_LAYER + 10 && !(seen_done && cyc > done_cyc + 2)) begin
      if (cyc > start_hold) bus.start = 1'b0;
      if (bus.busy !== !seen_done) busy_bad++;
      if (bus.done) begin
        done_cnt++;
        if (!seen_done) begin
          seen_done = 1'b1;
          done_cyc  = cyc;
`ifdef SNN_ARGMAX_EN
          begin
            int bi, bv;
            bi = 0; bv = 0;
            for (int k = 0; k < N_OUT; k++)
              if (k == 0 || int'($signed(exp_data[k])) > bv) begin
                bi = k; bv = int'($signed(exp_data[k]));
              end
            chk({tag, "_max_idx"}, 32'(bus.max_idx), 32'(bi));
            chk({tag, "_max_val"}, 32'(bus.max_val), 32'(8'(bv)));
          end
`endif
        end
      end
      if (bus.mac_en) begin
        if (pa_in !== IN_AW'(en_cnt % N_IN) || pa_w !== W_AW'(en_cnt)) iss_bad++;
        en_cnt++;
      end
      if (!bus.mac_clr_n) clr_cnt++;
      if (bus.out_we) begin
        chk({tag, "_out_addr"}, 32'(bus.out_addr), 32'(wr_n % N_OUT));
        chk({tag, "_out_data"}, 32'(bus.out_data), 32'(exp_data[wr_n % N_OUT]));
        wr_n++;
      end
      pa_in = bus.addr_in;
      pa_w  = bus.addr_w;
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    chk({tag, "_done_cycle"}, 32'(done_cyc), 32'(T_LAYER));
    chk({tag, "_done_count"}, 32'(done_cnt), 1);
    chk({tag, "_busy_bad"},   32'(busy_bad), 0);
    chk({tag, "_issue_bad"},  32'(iss_bad), 0);
    chk({tag, "_mac_en_cyc"}, 32'(en_cnt), 32'(N_OUT * N_IN));
    chk({tag, "_clr_cyc"},    32'(clr_cnt), 32'(N_OUT));
    chk({tag, "_writes"},     32'(wr_n), 32'(N_OUT));
  endtask

  // Reset asserted in the middle of neuron 1's issue phase.
  task automatic run_abort();
    int wr, bad;
    wr = 0; bad = 0;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 1; c < N_IN + 9; c++) begin
      if (bus.out_we) wr++;
      @(negedge clk);
    end
    chk("abort_pre_busy",   32'(bus.busy), 1);
    chk("abort_pre_mac_en", 32'(bus.mac_en), 1);
    chk("abort_pre_writes", 32'(wr), 1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("abort");
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.out_we) wr++;
      if (bus.busy || bus.done || bus.mac_en) bad++;
    end
    chk("abort_no_write", 32'(wr), 1);
    chk("abort_idle",     32'(bad), 0);
  endtask

  initial begin
    logic [10:0] sat_exp [0:3];
    logic [25:0] sat_in  [0:3];
    sat_in[0] = 26'h0020000; sat_exp[0] = 11'h3FF;
    sat_in[1] = 26'h3FC0000; sat_exp[1] = 11'h400;
    sat_in[2] = 26'h0000380; sat_exp[2] = 11'h007;
    sat_in[3] = 26'h3FFFF80; sat_exp[3] = 11'h7FF;
    am_vals[0] = 8'd5; am_vals[1] = 8'hFD; am_vals[2] = 8'd9; am_vals[3] = 8'd9;
    bus.start = 1'b0;
    randomize_env();

    repeat (3) @(negedge clk);
    check_reset_vals("reset");
`ifdef SNN_ARGMAX_EN
    chk("reset_max_idx", 32'(bus.max_idx), 0);
    chk("reset_max_val", 32'(bus.max_val), 0);
`endif
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_pass("rand0", 0);
    randomize_env();
    run_pass("rand1_start_held", 6);

    lut_mode = 1;
    run_pass("lut_n", 0);
    lut_mode = 0;

    force_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      force_val = $signed(sat_in[k]);
      run_pass("sat", 0);
      chk("sat_addr_lut", 32'(bus.addr_lut), 32'(sat_exp[k]));
      chk("sat_ref_model", 32'(ref_lut_addr(int'(force_val))), 32'(sat_exp[k]));
    end
    force_en = 1'b0;

    randomize_env();
    run_abort();
    run_pass("after_abort", 0);

`ifdef SNN_ARGMAX_EN
    lut_mode = 2;
    run_pass("argmax", 0);
    chk("argmax_idx_hold", 32'(bus.max_idx), 2);
    chk("argmax_val_hold", 32'(bus.max_val), 9);
    lut_mode = 0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
